// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I-subset control FSM (lw, sw, R/I ALU, beq, jal)
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5       instruction fields from the instruction register
//   Zero                       ALU zero flag
//   MemReady                   memory completes the current access this cycle
//   MemReq, MemWrite, AdrSrc   memory request, write strobe, address select
//   PCWrite, IRWrite, RegWrite architectural state enables
//   ResultSrc, ALUSrcA/B       datapath mux selects
//   ALUControl                 ALU operation
//   ImmSrc                     immediate format, decoded from op in every state
//   Illegal                    unsupported opcode seen in DECODE (one cycle)
//
// Optional feature: define MULTICYCLE_BNE_EN to let the BEQ state also
// resolve bne (PCWrite = Zero ^ funct3[0]).

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Main state decode: next state and datapath controls.
    always_comb begin
        state_d   = S_FETCH;
        MemReq    = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        alu_op    = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // PC+4 and the fetched word are captured only once memory answers.
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                state_d   = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch/jump target (OldPC + imm) is precomputed into ALUOut here.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemReq  = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
`ifdef MULTICYCLE_BNE_EN
                // funct3[0] distinguishes bne from beq.
                PCWrite = Zero ^ funct3[0];
`else
                PCWrite = Zero;
`endif
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC <= ALUOut (target from DECODE); ALU computes OldPC+4 for rd.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every architectural write in the cycle it is seen.
        if (reset) begin
            MemReq   = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // ALU operation decode.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5]=1) may subtract; addi ignores Instr[30].
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format decode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] outs;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign outs = {MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUControl, RegWrite, ImmSrc, Illegal};

    function automatic logic [17:0] mk(input logic mreq, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic rw,
                                       input logic [1:0] imm, input logic ill);
        return {mreq, pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, ill};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic mr, input logic z, input logic rst);
        @(negedge clk);
        MemReady = mr;
        Zero     = z;
        reset    = rst;
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] ev;
        op = 7'b0110011;
        ev = mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            checks++;
            if (outs !== ev) begin
                errors++;
                $display("FAIL reset cycle %0d got %h expected %h", i, outs, ev);
            end
        end
    endtask

    task automatic test_rtype_sub();
        logic [17:0] ev [5];
        logic        mr [5];
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b00,0);
        ev[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b00,0);
        ev[3] = mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,2'b00,0);
        ev[4] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(mr[i], 1'b0, 1'b0);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL rtype_sub cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops  [8];
        logic [2:0] f3s  [8];
        logic       f7s  [8];
        logic [2:0] alus [8];
        logic [17:0] ev [5];
        logic        mr [5];
        ops  = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
        f3s  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b000, 3'b110};
        f7s  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        alus = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b011};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
            ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
            ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b00,0);
            ev[2] = mk(0,0,0,0,0,2'b00,2'b10,(k >= 6) ? 2'b01 : 2'b00,alus[k],0,2'b00,0);
            ev[3] = mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,2'b00,0);
            ev[4] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
            for (int i = 0; i < 5; i++) begin
                drive(mr[i], 1'b0, 1'b0);
                checks++;
                if (outs !== ev[i]) begin
                    errors++;
                    $display("FAIL alu_decode case %0d cycle %0d got %h expected %h", k, i, outs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [17:0] ev [11];
        logic        mr [11];
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        ev[0]  = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        ev[1]  = ev[0];
        ev[2]  = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        ev[3]  = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b00,0);
        ev[4]  = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b00,0);
        ev[5]  = mk(1,0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,2'b00,0);
        ev[6]  = ev[5];
        ev[7]  = ev[5];
        ev[8]  = ev[5];
        ev[9]  = mk(0,0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,2'b00,0);
        ev[10] = ev[0];
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(mr[i], 1'b0, 1'b0);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL lw_stall cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_sw_stall();
        logic [17:0] ev [6];
        logic        mr [6];
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b01,0);
        ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b01,0);
        ev[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b01,0);
        ev[3] = mk(1,0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,2'b01,0);
        ev[4] = ev[3];
        ev[5] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b01,0);
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(mr[i], 1'b0, 1'b0);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL sw_stall cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [4];
        logic       zs  [4];
        logic       pcw [4];
        logic [17:0] ev [4];
        logic        mr [4];
        f3s = '{3'b000, 3'b000, 3'b001, 3'b001};
        zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MULTICYCLE_BNE_EN
        pcw = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        pcw = '{1'b1, 1'b0, 1'b0, 1'b1};
`endif
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        op = 7'b1100011; funct7b5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            funct3 = f3s[k];
            ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b10,0);
            ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b10,0);
            ev[2] = mk(0,pcw[k],0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b10,0);
            ev[3] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b10,0);
            for (int i = 0; i < 4; i++) begin
                drive(mr[i], zs[k], 1'b0);
                checks++;
                if (outs !== ev[i]) begin
                    errors++;
                    $display("FAIL branch case %0d cycle %0d got %h expected %h", k, i, outs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [17:0] ev [5];
        logic        mr [5];
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b11,0);
        ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b11,0);
        ev[2] = mk(0,1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,2'b11,0);
        ev[3] = mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,2'b11,0);
        ev[4] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b11,0);
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(mr[i], 1'b0, 1'b0);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL jal cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [17:0] ev [4];
        logic        mr [4];
        op = 7'b1110011; funct3 = 3'b000; funct7b5 = 1'b0;
        ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b00,1);
        ev[2] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b00,0);
        ev[3] = ev[2];
        mr = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(mr[i], 1'b0, 1'b0);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [17:0] ev [5];
        logic        mr [5];
        logic        rs [5];
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        ev[0] = mk(1,1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,2'b01,0);
        ev[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,2'b01,0);
        ev[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,2'b01,0);
        ev[3] = mk(0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,2'b01,0);
        ev[4] = mk(1,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,2'b01,0);
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(mr[i], 1'b0, rs[i]);
            checks++;
            if (outs !== ev[i]) begin
                errors++;
                $display("FAIL reset_mid_store cycle %0d got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_alu_decode();
        test_lw_stall();
        test_sw_stall();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM for the RV32I core subset: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Sequences a shared-ALU / single-memory datapath over 3–5 cycles per instruction.
- Drives the datapath muxes, register enables and ALU operation, and stalls on a memory ready handshake.
- Replaces the single-cycle controller when the core is built in multicycle mode.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction opcode (Instr[6:0], from the instruction register)
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- MemReq  out  1  memory access request
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- Illegal  out  1  unsupported opcode detected in DECODE

Behaviour:
- State register is 4 bits, updated on posedge clk. With reset=1, next state is FETCH.
- While reset=1, MemReq, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs follow the state.
- All outputs are combinational from state, op, funct3, funct7b5, Zero and MemReady. Unlisted outputs are 0.
- ImmSrc is decoded from op in every state:
  - lw / I-type: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - other opcodes: 00
- Internal ALUOp drives ALU decoding:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10, funct3=000: sub if op[5] & funct7b5, else add.
  - ALUOp 10, funct3=010: slt. 110: or. 111: and. Any other funct3: add.
- FETCH:
  - AdrSrc=0, MemReq=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jump target into ALUOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other op -> FETCH with Illegal=1 for this cycle only. No architectural state is written.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00, MemReq=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemReq=1, MemWrite=1.
  - MemWrite stays high for every stall cycle. Leave to FETCH in the cycle MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- Latency with MemReady held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- Each stall cycle adds one cycle in the stalled state.
- Reset asserted mid-instruction: the next state is FETCH. Writes to the register file, memory and PC are suppressed in that same cycle.
- Unencoded state values go to FETCH.

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- Defined: the BEQ state also handles bne (funct3=001), with PCWrite = Zero XOR funct3[0]; blt/bge are not covered.
- Not defined: PCWrite = Zero regardless of funct3, and bne behaves as beq.

Test Plan:
- Reset held 2 cycles, then op=0110011, funct3=000, funct7b5=1, MemReady=1 -> states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB. Back in FETCH at cycle 4.
- lw (op=0000011) with MemReady=0 for 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite pulse once. 10 cycles total; RegWrite=1 with ResultSrc=01 in MEMWB.
- sw (op=0100011), MemReady low 1 cycle in MEMWRITE -> MemWrite=1, AdrSrc=1 for 2 cycles. RegWrite never asserted. ImmSrc=01.
- beq with Zero=1, then Zero=0 -> PCWrite=1 then 0 in the BEQ cycle; ALUControl=001. With MULTICYCLE_BNE_EN and funct3=001, the Zero=0 case gives PCWrite=1.
- jal (op=1101111) -> JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUWB follows with RegWrite=1; ImmSrc=11.
- op=1110011 -> Illegal=1 for exactly the DECODE cycle, then FETCH. Separately, reset raised during MEMWRITE -> MemWrite=0 that cycle and the state is FETCH next.
